// File: rtl/bcd_count_ctrl_pkg.sv
// Shared types and helpers for the 3-digit BCD count controller.
//   bcd3_t           : packed BCD {hundreds, tens, ones}
//   bcd_ctrl_state_t : controller FSM states
//   BCD3_MAX         : largest representable count (999)
//   bcd_valid()      : 1 when every digit of a bcd3_t is in 0..9
package bcd_count_ctrl_pkg;

  typedef logic [11:0] bcd3_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } bcd_ctrl_state_t;

  localparam bcd3_t BCD3_MAX = 12'h999;

  function automatic logic bcd_valid(input bcd3_t v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_count_ctrl_if.sv
// Command/status bundle between a host and the BCD count controller.
//   start/stop/clear/load : level-sampled commands from the host
//   load_val, limit       : packed BCD operands from the host
//   count                 : packed BCD count register
//   running/done/wrap/err : status back to the host
// Modports: master = host side, slave = controller side.
interface bcd_count_ctrl_if;
  import bcd_count_ctrl_pkg::*;

  logic  start;
  logic  stop;
  logic  clear;
  logic  load;
  bcd3_t load_val;
  bcd3_t limit;
  bcd3_t count;
  logic  running;
  logic  done;
  logic  wrap;
  logic  err;

  modport master (
    output start, stop, clear, load, load_val, limit,
    input  count, running, done, wrap, err
  );

  modport slave (
    input  start, stop, clear, load, load_val, limit,
    output count, running, done, wrap, err
  );

endinterface

// File: rtl/bcd_count_ctrl_step.sv
// Combinational 3-digit BCD increment.
//   i_val     : packed BCD input
//   o_val     : i_val + 1 in BCD, carry rippling ones -> tens -> hundreds
//   o_carry   : 1 when the increment rolls 999 over to 000
// A digit holding an illegal code (>9) is forced to 0 when it is stepped and
// does not propagate a carry, so a corrupted register recovers by counting.
module bcd_step
  import bcd_count_ctrl_pkg::*;
(
  input  bcd3_t i_val,
  output bcd3_t o_val,
  output logic  o_carry
);

  // Returns {carry, next_digit}.
  function automatic logic [4:0] digit_inc(input logic [3:0] d);
    if (d == 4'd9)      return {1'b1, 4'd0};
    else if (d > 4'd9)  return {1'b0, 4'd0};
    else                return {1'b0, d + 4'd1};
  endfunction

  logic [4:0] w_ones;
  logic [4:0] w_tens;
  logic [4:0] w_hund;

  assign w_ones  = digit_inc(i_val[3:0]);
  assign w_tens  = w_ones[4] ? digit_inc(i_val[7:4])  : {1'b0, i_val[7:4]};
  assign w_hund  = w_tens[4] ? digit_inc(i_val[11:8]) : {1'b0, i_val[11:8]};

  assign o_val   = {w_hund[3:0], w_tens[3:0], w_ones[3:0]};
  assign o_carry = w_hund[4];

endmodule

// File: rtl/bcd_count_ctrl.sv
// Sequencer for a 3-digit BCD count register.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : command/status bundle (slave side), see bcd_count_ctrl_if
// Parameters:
//   TICK_DIV    : clk cycles per count tick while running (>=1)
//   AUTO_RELOAD : 1 = wrap to 000 at the limit and keep running,
//                 0 = hold the count and park in DONE
// Commands are prioritised clear > load > stop > start and only one acts in a
// cycle. A command that acts suppresses a coincident tick.
module bcd_count_ctrl
  import bcd_count_ctrl_pkg::*;
#(
  parameter int TICK_DIV    = 1000,
  parameter bit AUTO_RELOAD = 1'b0
)(
  input  logic             clk,
  input  logic             rst_n,
  bcd_count_ctrl_if.slave  bus
);

  localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

  bcd_ctrl_state_t r_state, w_state_nxt;
  logic [PW-1:0]   r_presc, w_presc_nxt;
  bcd3_t           r_count, w_count_nxt;
  logic            r_running;
  logic            r_done, w_done_nxt;
  logic            r_wrap, w_wrap_nxt;
  logic            r_err,  w_err_nxt;

  bcd3_t           w_limit_eff;
  logic            w_at_limit;
  logic            w_tick;
  bcd3_t           w_count_inc;
  logic            w_count_carry;

  bcd_step u_step (
    .i_val   (r_count),
    .o_val   (w_count_inc),
    .o_carry (w_count_carry)
  );

  // An unusable limit falls back to 999 so the count still terminates.
  assign w_limit_eff = bcd_valid(bus.limit) ? bus.limit : BCD3_MAX;
  assign w_at_limit  = (r_count == w_limit_eff);
  assign w_tick      = (r_state == RUN) && (r_presc == PRESC_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_count_nxt = r_count;
    w_done_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    if (bus.clear) begin
      w_state_nxt = IDLE;
      w_count_nxt = '0;
      w_presc_nxt = '0;
    end else if (bus.load) begin
      if (bcd_valid(bus.load_val)) begin
        w_count_nxt = bus.load_val;
        w_presc_nxt = '0;
        if (r_state == DONE) w_state_nxt = IDLE;
      end else begin
        w_err_nxt = 1'b1;
      end
    end else if (bus.stop && (r_state == RUN)) begin
      // Prescaler is left untouched so a resume finishes the partial tick.
      w_state_nxt = PAUSE;
    end else if (bus.start && (r_state != RUN)) begin
      w_state_nxt = RUN;
      unique case (r_state)
        IDLE:    w_presc_nxt = '0;
        DONE: begin
          w_presc_nxt = '0;
          w_count_nxt = '0;
        end
        default: ;
      endcase
    end else if (r_state == RUN) begin
      if (w_tick) begin
        w_presc_nxt = '0;
        if (w_at_limit) begin
          if (AUTO_RELOAD) begin
            w_count_nxt = '0;
            w_wrap_nxt  = 1'b1;
          end else begin
            w_done_nxt  = 1'b1;
            w_state_nxt = DONE;
          end
        end else begin
          // A limit below the current count lets the count run through
          // 999 and roll over naturally.
          w_count_nxt = w_count_inc;
          w_wrap_nxt  = w_count_carry;
        end
      end else begin
        w_presc_nxt = r_presc + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_presc   <= '0;
      r_count   <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_wrap    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_count   <= w_count_nxt;
      r_running <= (w_state_nxt == RUN);
      r_done    <= w_done_nxt;
      r_wrap    <= w_wrap_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign bus.count   = r_count;
  assign bus.running = r_running;
  assign bus.done    = r_done;
  assign bus.wrap    = r_wrap;
  assign bus.err     = r_err;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
module tb_bcd_count_ctrl;
  import bcd_count_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  bcd3_t q[$];

  bcd_count_ctrl_if if0 ();
  bcd_count_ctrl_if if1 ();

  bcd_count_ctrl #(.TICK_DIV(4), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  bcd_count_ctrl #(.TICK_DIV(4), .AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cmds();
    if0.start = 0; if0.stop = 0; if0.clear = 0; if0.load = 0;
    if1.start = 0; if1.stop = 0; if1.clear = 0; if1.load = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_cmds();
    if0.load_val = 12'h000; if0.limit = 12'h999;
    if1.load_val = 12'h000; if1.limit = 12'h999;
    step(); step();
    n_checks++;
    if ({if0.count, if0.running, if0.done, if0.wrap, if0.err} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_state: got count=%h run=%b done=%b wrap=%b err=%b, want all 0",
               if0.count, if0.running, if0.done, if0.wrap, if0.err);
    end
    rst_n = 1'b1;
    step();
    // Mid-RUN reset with count 045.
    if0.load = 1; if0.load_val = 12'h045; step(); if0.load = 0;
    if0.start = 1; step(); if0.start = 0;
    step();
    n_checks++;
    if (if0.count !== 12'h045 || if0.running !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_setup: got count=%h run=%b, want 045/1", if0.count, if0.running);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (if0.count !== 12'h000 || if0.running !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got count=%h run=%b, want 000/0", if0.count, if0.running);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_count_done();
    bcd3_t prev;
    int since, ndone;
    if0.clear = 1; step(); if0.clear = 0;
    if0.limit = 12'h012;
    q.delete();
    for (int i = 1; i <= 12; i++) q.push_back(bcd3_t'(((i / 10) << 4) | (i % 10)));
    if0.start = 1; step(); if0.start = 0;
    prev = 12'h000; since = 0; ndone = 0;
    for (int c = 0; c < 80; c++) begin
      step();
      since++;
      if (if0.count !== prev) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL count_seq: unexpected count %h", if0.count);
        end else if (if0.count !== q[0] || since != 4) begin
          n_fail++;
          $display("FAIL count_seq: got %h after %0d clk, want %h after 4", if0.count, since, q[0]);
        end
        if (q.size() != 0) void'(q.pop_front());
        prev = if0.count; since = 0;
      end
      if (if0.done === 1'b1) begin
        ndone++;
        n_checks++;
        if (if0.count !== 12'h012) begin
          n_fail++;
          $display("FAIL done_count: got %h, want 012", if0.count);
        end
      end
    end
    n_checks++;
    if (ndone != 1 || q.size() != 0 || if0.count !== 12'h012 || if0.running !== 1'b0) begin
      n_fail++;
      $display("FAIL done_final: done_pulses=%0d left=%0d count=%h run=%b, want 1/0/012/0",
               ndone, q.size(), if0.count, if0.running);
    end
  endtask

  task automatic test_auto_reload();
    bcd3_t prev;
    int nwrap, run_drop, c;
    if1.clear = 1; step(); if1.clear = 0;
    if1.limit = 12'h999;
    if1.load = 1; if1.load_val = 12'h998; step(); if1.load = 0;
    q.delete(); q.push_back(12'h999); q.push_back(12'h000);
    if1.start = 1; step(); if1.start = 0;
    prev = 12'h998; nwrap = 0; run_drop = 0; c = 0;
    while (q.size() != 0 && c < 20) begin
      step(); c++;
      if (if1.running !== 1'b1) run_drop++;
      if (if1.wrap === 1'b1) nwrap++;
      if (if1.count !== prev) begin
        n_checks++;
        if (if1.count !== q[0]) begin
          n_fail++;
          $display("FAIL reload_seq: got %h, want %h", if1.count, q[0]);
        end
        n_checks++;
        if (q[0] == 12'h000 && if1.wrap !== 1'b1) begin
          n_fail++;
          $display("FAIL reload_wrap: got wrap=%b at 000, want 1", if1.wrap);
        end
        void'(q.pop_front());
        prev = if1.count;
      end
    end
    step();
    n_checks++;
    if (q.size() != 0 || nwrap != 1 || run_drop != 0 || if1.wrap !== 1'b0 || if1.running !== 1'b1) begin
      n_fail++;
      $display("FAIL reload_final: left=%0d wraps=%0d run_drops=%0d wrap_now=%b run=%b, want 0/1/0/0/1",
               q.size(), nwrap, run_drop, if1.wrap, if1.running);
    end
    if1.clear = 1; step(); if1.clear = 0;
  endtask

  task automatic test_pause_resume();
    if0.clear = 1; step(); if0.clear = 0;
    if0.limit = 12'h999;
    if0.start = 1; step(); if0.start = 0;
    step(); step();
    if0.stop = 1; step(); if0.stop = 0;
    n_checks++;
    if (if0.running !== 1'b0 || if0.count !== 12'h000) begin
      n_fail++;
      $display("FAIL pause_enter: got run=%b count=%h, want 0/000", if0.running, if0.count);
    end
    for (int i = 0; i < 10; i++) step();
    n_checks++;
    if (if0.count !== 12'h000 || if0.running !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_hold: got count=%h run=%b, want 000/0", if0.count, if0.running);
    end
    q.delete(); q.push_back(12'h001);
    if0.start = 1; step(); if0.start = 0;
    step();
    n_checks++;
    if (if0.count !== 12'h000 || if0.running !== 1'b1) begin
      n_fail++;
      $display("FAIL resume_early: got count=%h run=%b, want 000/1", if0.count, if0.running);
    end
    step();
    n_checks++;
    if (if0.count !== q[0]) begin
      n_fail++;
      $display("FAIL resume_step: got %h, want %h 2 clk after resume", if0.count, q[0]);
    end
    void'(q.pop_front());
  endtask

  task automatic test_load();
    int c;
    if0.clear = 1; step(); if0.clear = 0;
    if0.load = 1; if0.load_val = 12'h0A5; step(); if0.load = 0;
    n_checks++;
    if (if0.err !== 1'b1 || if0.count !== 12'h000) begin
      n_fail++;
      $display("FAIL load_bad: got err=%b count=%h, want 1/000", if0.err, if0.count);
    end
    step();
    n_checks++;
    if (if0.err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pulse: got err=%b, want 0", if0.err);
    end
    if0.load = 1; if0.load_val = 12'h199; step(); if0.load = 0;
    n_checks++;
    if (if0.count !== 12'h199 || if0.err !== 1'b0) begin
      n_fail++;
      $display("FAIL load_good: got count=%h err=%b, want 199/0", if0.count, if0.err);
    end
    q.delete(); q.push_back(12'h200);
    if0.start = 1; step(); if0.start = 0;
    c = 0;
    while (if0.count === 12'h199 && c < 10) begin step(); c++; end
    n_checks++;
    if (if0.count !== q[0] || c != 4) begin
      n_fail++;
      $display("FAIL load_step: got %h after %0d clk, want %h after 4", if0.count, c, q[0]);
    end
    void'(q.pop_front());
  endtask

  task automatic test_simultaneous();
    if0.clear = 1; step(); if0.clear = 0;
    if0.load = 1; if0.load_val = 12'h045; step(); if0.load = 0;
    if0.start = 1; step(); if0.start = 0;
    step(); step();
    if0.clear = 1; if0.load = 1; if0.load_val = 12'h123; if0.start = 1;
    step();
    idle_cmds();
    n_checks++;
    if (if0.count !== 12'h000 || if0.running !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_prio: got count=%h run=%b, want 000/0", if0.count, if0.running);
    end
    if0.start = 1; step(); if0.start = 0;
    step(); step(); step();
    if0.stop = 1; step(); if0.stop = 0;
    n_checks++;
    if (if0.count !== 12'h000 || if0.running !== 1'b0) begin
      n_fail++;
      $display("FAIL tick_stop: got count=%h run=%b, want 000/0", if0.count, if0.running);
    end
    step();
    n_checks++;
    if (if0.count !== 12'h000) begin
      n_fail++;
      $display("FAIL tick_stop_hold: got %h, want 000", if0.count);
    end
  endtask

  task automatic test_limit_edges();
    bcd3_t prev;
    int ndone, nwrap, c;
    // Limit below the count: run through 999 and roll over, no done.
    if0.clear = 1; step(); if0.clear = 0;
    if0.limit = 12'h012;
    if0.load = 1; if0.load_val = 12'h997; step(); if0.load = 0;
    q.delete(); q.push_back(12'h998); q.push_back(12'h999); q.push_back(12'h000);
    if0.start = 1; step(); if0.start = 0;
    prev = 12'h997; ndone = 0; nwrap = 0; c = 0;
    while (q.size() != 0 && c < 30) begin
      step(); c++;
      if (if0.done === 1'b1) ndone++;
      if (if0.wrap === 1'b1) nwrap++;
      if (if0.count !== prev) begin
        n_checks++;
        if (if0.count !== q[0]) begin
          n_fail++;
          $display("FAIL over_limit_seq: got %h, want %h", if0.count, q[0]);
        end
        void'(q.pop_front());
        prev = if0.count;
      end
    end
    n_checks++;
    if (q.size() != 0 || ndone != 0 || nwrap != 1 || if0.running !== 1'b1) begin
      n_fail++;
      $display("FAIL over_limit_final: left=%0d done=%0d wraps=%0d run=%b, want 0/0/1/1",
               q.size(), ndone, nwrap, if0.running);
    end
    // Invalid limit behaves as 999.
    if0.clear = 1; step(); if0.clear = 0;
    if0.limit = 12'h0FF;
    if0.load = 1; if0.load_val = 12'h998; step(); if0.load = 0;
    if0.start = 1; step(); if0.start = 0;
    c = 0;
    while (if0.done !== 1'b1 && c < 20) begin step(); c++; end
    n_checks++;
    if (if0.done !== 1'b1 || if0.count !== 12'h999) begin
      n_fail++;
      $display("FAIL bad_limit: got done=%b count=%h, want 1/999", if0.done, if0.count);
    end
    step();
    n_checks++;
    if (if0.done !== 1'b0 || if0.running !== 1'b0 || if0.count !== 12'h999) begin
      n_fail++;
      $display("FAIL bad_limit_hold: got done=%b run=%b count=%h, want 0/0/999",
               if0.done, if0.running, if0.count);
    end
    // Start from DONE restarts at 000.
    if0.start = 1; step(); if0.start = 0;
    n_checks++;
    if (if0.count !== 12'h000 || if0.running !== 1'b1) begin
      n_fail++;
      $display("FAIL done_restart: got count=%h run=%b, want 000/1", if0.count, if0.running);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_count_done();
    test_auto_reload();
    test_pause_resume();
    test_load();
    test_simultaneous();
    test_limit_edges();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
